id_ex_stage: RTL and testbench

Decode-to-execute pipeline register that feeds the ALU (`aluCtr`, `A`, `B`) one cycle after decode. It selects the B operand (register or immediate) and resolves read-after-write hazards, either by forwarding or by interlocking. It inserts bubbles on load-use hazards and flushes, and keeps a saturating stall counter for performance measurement.

---
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand-B select, RAW hazard resolution, bubbles, saturating stall counter.
// Optional feature macro: ID_EX_FORWARD_EN (forwarding with load-use-only stalls; interlock-only otherwise).
module id_ex_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [3:0]             id_alu_ctr,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [31:0]            id_rs_data,
  input  logic [31:0]            id_rt_data,
  input  logic [31:0]            id_imm,
  input  logic                   id_alu_src,
  input  logic [4:0]             id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   flush,
  input  logic [31:0]            ex_alu_out,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_reg_write,
  input  logic [31:0]            mem_data,
  output logic                   ex_valid,
  output logic [3:0]             ex_alu_ctr,
  output logic [31:0]            ex_a,
  output logic [31:0]            ex_b,
  output logic [4:0]             ex_rd,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic [3:0]  alu_ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
  } ex_pkt_t;

  state_t  state, state_n;
  ex_pkt_t pkt_d;
  logic ex_live, mem_live, rt_used;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic hazard, issue, stall_evt;
  logic [31:0] rs_val, rt_val;

  // Register 0 is excluded here, so it never matches a source.
  assign ex_live  = ex_valid & ex_reg_write & (ex_rd != 5'd0);
  assign mem_live = mem_reg_write & (mem_rd != 5'd0);
  assign rt_used  = ~id_alu_src;

  assign rs_ex  = ex_live  & (id_rs == ex_rd);
  assign rt_ex  = ex_live  & rt_used & (id_rt == ex_rd);
  assign rs_mem = mem_live & (id_rs == mem_rd);
  assign rt_mem = mem_live & rt_used & (id_rt == mem_rd);

`ifdef ID_EX_FORWARD_EN
  // EX wins over MEM; only a load in EX cannot be forwarded yet.
  assign hazard = ex_mem_read & (rs_ex | rt_ex);
  assign rs_val = rs_ex ? ex_alu_out : (rs_mem ? mem_data : id_rs_data);
  assign rt_val = rt_ex ? ex_alu_out : (rt_mem ? mem_data : id_rt_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_alu_out, mem_data};
  assign hazard = rs_ex | rt_ex | rs_mem | rt_mem;
  assign rs_val = id_rs_data;
  assign rt_val = id_rt_data;
`endif

  assign id_ready  = ~rst_n | flush | ~(id_valid & hazard);
  assign issue     = id_valid & ~flush & ~hazard;
  assign stall_evt = id_valid & ~id_ready & ~flush;

  always_comb begin
    pkt_d           = '0;
    pkt_d.alu_ctr   = id_alu_ctr;
    pkt_d.a         = rs_val;
    pkt_d.b         = id_alu_src ? id_imm : rt_val;
    pkt_d.rd        = id_rd;
    pkt_d.reg_write = id_reg_write;
    pkt_d.mem_read  = id_mem_read;
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (id_valid & hazard & ~flush) state_n = STALL;
      STALL:   if (flush | ~(id_valid & hazard)) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  // Anything not issued becomes an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alu_ctr   <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_valid     <= issue;
      ex_alu_ctr   <= issue ? pkt_d.alu_ctr   : 4'b0000;
      ex_a         <= issue ? pkt_d.a         : 32'd0;
      ex_b         <= issue ? pkt_d.b         : 32'd0;
      ex_rd        <= issue ? pkt_d.rd        : 5'd0;
      ex_reg_write <= issue & pkt_d.reg_write;
      ex_mem_read  <= issue & pkt_d.mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (stall_evt && ~&stall_cnt)   stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard cases plus randomized traffic vs a source-level model.
module tb_id_ex_stage;
  localparam int W    = 4;
  localparam int CMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic id_valid = 0, id_alu_src = 0, id_reg_write = 0, id_mem_read = 0, flush = 0;
  logic mem_reg_write = 0;
  logic [3:0] id_alu_ctr = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0, mem_rd = 0;
  logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0, ex_alu_out = 0, mem_data = 0;
  logic id_ready, ex_valid, ex_reg_write, ex_mem_read;
  logic [3:0] ex_alu_ctr;
  logic [31:0] ex_a, ex_b;
  logic [4:0] ex_rd;
  logic [W-1:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.STALL_CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_ctr(id_alu_ctr), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .ex_alu_out(ex_alu_out),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_data(mem_data),
    .ex_valid(ex_valid), .ex_alu_ctr(ex_alu_ctr), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [3:0]  ctr;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        rw, mr;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  // Model: what sits in EX now, what sat there last cycle (now in MEM), and the stall count.
  bit m_valid, m_rw, m_mr, pm_live;
  logic [4:0] m_rd, pm_rd;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One decode cycle: called just after a falling edge with id_* set, returns after the next falling edge.
  task automatic step(output bit acc);
    bit haz, rdy, m_live;
    logic [31:0] v[2];
    logic [4:0] src[2];
    bit used[2];
    mem_rd        = pm_rd;
    mem_reg_write = pm_live;
    #1;
    m_live = m_valid && m_rw && (m_rd != 0);
    src[0] = id_rs; src[1] = id_rt;
    used[0] = 1'b1; used[1] = !id_alu_src;
    v[0] = id_rs_data; v[1] = id_rt_data;
    haz = 0;
    for (int i = 0; i < 2; i++) begin
      if (used[i]) begin
        if (m_live && src[i] == m_rd) begin
`ifdef ID_EX_FORWARD_EN
          if (m_mr) haz = 1;
          v[i] = ex_alu_out;
`else
          haz = 1;
`endif
        end else if (mem_reg_write && mem_rd != 0 && src[i] == mem_rd) begin
`ifdef ID_EX_FORWARD_EN
          v[i] = mem_data;
`else
          haz = 1;
`endif
        end
      end
    end
    rdy = flush || !(id_valid && haz);
    acc = id_valid && !flush && !haz;
    chk("id_ready", {31'd0, id_ready}, {31'd0, rdy});
    chk("stall_cnt", {28'd0, stall_cnt}, m_cnt);
    if (id_valid && !rdy && !flush && m_cnt < CMAX) m_cnt++;
    pm_live = m_valid && m_rw;
    pm_rd   = m_rd;
    if (acc) begin
      q.push_back('{id_alu_ctr, v[0], id_alu_src ? id_imm : v[1], id_rd, id_reg_write, id_mem_read});
      m_valid = 1; m_rd = id_rd; m_rw = id_reg_write; m_mr = id_mem_read;
    end else begin
      m_valid = 0; m_rd = 0; m_rw = 0; m_mr = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue();
    bit acc;
    int n = 0;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 5);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: instruction not accepted within %0d cycles", n);
    end
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input bit src, input bit rw, input bit mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_alu_src = src; id_reg_write = rw; id_mem_read = mr;
    id_alu_ctr = 4'b0010;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    flush = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 0);
    chk("rst_ex_a", ex_a, 0);
    chk("rst_ex_b", ex_b, 0);
    chk("rst_stall_cnt", {28'd0, stall_cnt}, 0);
    chk("rst_id_ready", {31'd0, id_ready}, 1);
    chk("queue_drain", q.size(), 0);
    q.delete();
    m_valid = 0; m_rw = 0; m_mr = 0; m_rd = 0; pm_live = 0; pm_rd = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every real instruction leaving the register must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        if (ex_valid) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ex_unexpected: got ex_valid=1 expected no instruction at %0t", $time);
          end else begin
            e = q.pop_front();
            chk("ex_alu_ctr", {28'd0, ex_alu_ctr}, {28'd0, e.ctr});
            chk("ex_a", ex_a, e.a);
            chk("ex_b", ex_b, e.b);
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
            chk("ex_ctl", {30'd0, ex_reg_write, ex_mem_read}, {30'd0, e.rw, e.mr});
          end
        end else begin
          chk("bubble_ctr", {28'd0, ex_alu_ctr}, 0);
          chk("bubble_ab", ex_a | ex_b, 0);
          chk("bubble_ctl", {30'd0, ex_reg_write, ex_mem_read}, 0);
        end
      end
    end
  end

  initial begin
    bit acc, hold;
    #2;
    do_reset();

    // Reset in the middle of a load-use stall.
    repeat (3) begin
      set_id(1, 1, 2, 5, 0, 1, 1); issue();
      set_id(1, 5, 2, 6, 0, 1, 0); issue();
    end
    set_id(1, 1, 2, 5, 0, 1, 1); issue();
    set_id(1, 5, 2, 6, 0, 1, 0); step(acc);
`ifdef ID_EX_FORWARD_EN
    chk("mid_stall_cnt", {28'd0, stall_cnt}, 4);
`else
    chk("mid_stall_cnt", {28'd0, stall_cnt}, 7);
`endif
    do_reset();

    // EX producer feeding rs.
    set_id(1, 1, 2, 3, 0, 1, 0); issue();
    set_id(1, 3, 2, 4, 0, 1, 0);
    id_rs_data = 32'h99; id_rt_data = 32'h5; ex_alu_out = 32'h10;
    issue();
`ifdef ID_EX_FORWARD_EN
    chk("exfwd_a", ex_a, 32'h10);
    chk("exfwd_cnt", {28'd0, stall_cnt}, 0);
`else
    chk("exfwd_a", ex_a, 32'h99);
    chk("exfwd_cnt", {28'd0, stall_cnt}, 2);
`endif
    chk("exfwd_b", ex_b, 32'h5);
    do_reset();

    // Load-use on rt.
    set_id(1, 1, 2, 5, 0, 1, 1); issue();
    set_id(1, 1, 5, 6, 0, 1, 0);
    id_rt_data = 32'h1234_5678; mem_data = 32'hDEAD_BEEF;
    issue();
`ifdef ID_EX_FORWARD_EN
    chk("lduse_b", ex_b, 32'hDEAD_BEEF);
    chk("lduse_cnt", {28'd0, stall_cnt}, 1);
`else
    chk("lduse_b", ex_b, 32'h1234_5678);
    chk("lduse_cnt", {28'd0, stall_cnt}, 2);
`endif
    do_reset();

    // EX over MEM priority.
    set_id(1, 1, 2, 7, 0, 1, 0); issue();
    set_id(1, 1, 2, 7, 0, 1, 0); issue();
    set_id(1, 7, 2, 8, 0, 1, 0);
    id_rs_data = 32'h77; ex_alu_out = 32'h1; mem_data = 32'h2;
    issue();
`ifdef ID_EX_FORWARD_EN
    chk("prio_a", ex_a, 32'h1);
`else
    chk("prio_a", ex_a, 32'h77);
`endif
    do_reset();

    // r0 producer never forwards or stalls.
    set_id(1, 1, 2, 0, 0, 1, 0); issue();
    set_id(1, 0, 0, 9, 0, 1, 0);
    id_rs_data = 32'h55; id_rt_data = 32'h66;
    issue();
    chk("r0_a", ex_a, 32'h55);
    chk("r0_b", ex_b, 32'h66);
    chk("r0_cnt", {28'd0, stall_cnt}, 0);
    do_reset();

    // Immediate B hides an rt match against a load.
    set_id(1, 1, 2, 9, 0, 1, 1); issue();
    set_id(1, 1, 9, 10, 1, 1, 0);
    id_imm = 32'h1234;
    issue();
    chk("imm_b", ex_b, 32'h1234);
    chk("imm_cnt", {28'd0, stall_cnt}, 0);
    do_reset();

    // Flush during a load-use stall.
    set_id(1, 1, 2, 5, 0, 1, 1); issue();
    set_id(1, 1, 5, 6, 0, 1, 0);
    flush = 1;
    #1;
    chk("flush_ready", {31'd0, id_ready}, 1);
    step(acc);
    chk("flush_valid", {31'd0, ex_valid}, 0);
    chk("flush_cnt", {28'd0, stall_cnt}, 0);
    flush = 0; id_valid = 0;
    do_reset();

    // Chain of dependent loads drives the counter into saturation.
    set_id(1, 5, 5, 5, 0, 1, 1);
    repeat (21) issue();
    chk("sat_cnt", {28'd0, stall_cnt}, CMAX);
    id_valid = 0;
    do_reset();

    // Randomized traffic; decode holds a stalled instruction until accepted or flushed.
    repeat (4) begin
      hold = 0;
      repeat (250) begin
        if (!hold) begin
          id_valid     = ($urandom_range(0, 9) < 8);
          id_rs        = 5'($urandom_range(0, 5));
          id_rt        = 5'($urandom_range(0, 5));
          id_rd        = 5'($urandom_range(0, 5));
          id_alu_src   = ($urandom_range(0, 3) == 0);
          id_reg_write = ($urandom_range(0, 3) != 0);
          id_mem_read  = ($urandom_range(0, 2) == 0);
          id_alu_ctr   = 4'($urandom_range(0, 6));
          id_rs_data   = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        end
        flush      = ($urandom_range(0, 19) == 0);
        ex_alu_out = $urandom;
        mem_data   = $urandom;
        step(acc);
        hold = id_valid && !acc && !flush;
      end
      flush = 0; id_valid = 0;
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
